ls_deglitch_inverter_bank: RTL and testbench



---
 rtl/ls_logic_pkg.sv | 17 +
 rtl/ls_deglitch_channel.sv | 65 ++++++
 rtl/ls_deglitch_inverter_bank.sv | 67 ++++++
 tb/tb_ls_deglitch_inverter_bank.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_logic_pkg.sv
// Shared constants and helpers for the level-shifter / deglitch I/O blocks.
// Defaults mirror a discrete hex inverter with a short stability filter.
package ls_logic_pkg;

    localparam int unsigned LS_DEFAULT_CHANNELS = 6;
    localparam int unsigned LS_DEFAULT_SYNC     = 2;
    localparam int unsigned LS_DEFAULT_FILTER   = 4;

    localparam logic POL_INVERT = 1'b1;
    localparam logic POL_PASS   = 1'b0;

    // Stability counter width; a one-cycle filter still keeps a 1-bit counter.
    function automatic int unsigned ls_cnt_width(input int unsigned filter_cycles);
        return (filter_cycles <= 1) ? 1 : $clog2(filter_cycles);
    endfunction

endpackage

// File: rtl/ls_deglitch_channel.sv
// One channel: input synchroniser, stability counter and accepted state s.
// commit_c is high in the cycle whose edge loads a new value into s.
module ls_deglitch_channel
    import ls_logic_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = LS_DEFAULT_SYNC,
    parameter int unsigned FILTER_CYCLES = LS_DEFAULT_FILTER
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic hold,
    output logic s,
    output logic commit_c
);

    localparam int unsigned       CNT_W    = ls_cnt_width(FILTER_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   s_d;

    assign sync = sync_q[SYNC_STAGES-1];

    // Synchroniser keeps shifting regardless of hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a};
        end
    end

    // Filter: accept sync once it has differed from s for FILTER_CYCLES edges.
    always_comb begin
        cnt_d    = cnt_q;
        s_d      = s;
        commit_c = 1'b0;
        if (!hold) begin
            if (sync == s) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                s_d      = sync;
                cnt_d    = '0;
                commit_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s     <= 1'b0;
            cnt_q <= '0;
        end else begin
            s     <= s_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ls_deglitch_inverter_bank.sv
// Bank of synchronised, deglitched inverter/buffer channels with a
// runtime polarity register; y is the accepted state XOR polarity.
module ls_deglitch_inverter_bank
    import ls_logic_pkg::*;
#(
    parameter int unsigned CHANNELS      = LS_DEFAULT_CHANNELS,
    parameter int unsigned SYNC_STAGES   = LS_DEFAULT_SYNC,
    parameter int unsigned FILTER_CYCLES = LS_DEFAULT_FILTER
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] a,
    input  logic                hold,
    input  logic                cfg_we,
    input  logic [CHANNELS-1:0] cfg_pol,
    output logic [CHANNELS-1:0] pol,
    output logic [CHANNELS-1:0] y,
    output logic [CHANNELS-1:0] chg
);

    if (CHANNELS == 0) begin : g_bad_channels
        $fatal(1, "ls_deglitch_inverter_bank: CHANNELS must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "ls_deglitch_inverter_bank: SYNC_STAGES must be >= 2");
    end
    if (FILTER_CYCLES == 0) begin : g_bad_filter
        $fatal(1, "ls_deglitch_inverter_bank: FILTER_CYCLES must be >= 1");
    end

    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] commit_c;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        ls_deglitch_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .a        (a[i]),
            .hold     (hold),
            .s        (s[i]),
            .commit_c (commit_c[i])
        );
    end

    // Polarity resets to invert so an idle-low bus reads all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pol <= {CHANNELS{POL_INVERT}};
        end else if (cfg_we) begin
            pol <= cfg_pol;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg <= '0;
        end else begin
            chg <= commit_c;
        end
    end

    assign y = s ^ pol;

endmodule

// File: tb/tb_ls_deglitch_inverter_bank.sv
// Self-checking bench: directed vector table, hand sequences for reset,
// polarity, hold and the unfiltered configuration, then random traffic.
module tb_ls_deglitch_inverter_bank;

    localparam int C1 = 6;
    localparam int S1 = 2;
    localparam int F1 = 4;
    localparam int S2 = 3;
    localparam int F2 = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [C1-1:0] a1, cfg_pol1, pol1, y1, chg1;
    logic          hold1, cfg_we1;
    logic [0:0]    a2, cfg_pol2, pol2, y2, chg2;
    logic          hold2, cfg_we2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ls_deglitch_inverter_bank u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .hold(hold1), .cfg_we(cfg_we1),
        .cfg_pol(cfg_pol1), .pol(pol1), .y(y1), .chg(chg1)
    );

    ls_deglitch_inverter_bank #(
        .CHANNELS(1), .SYNC_STAGES(S2), .FILTER_CYCLES(F2)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .a(a2), .hold(hold2), .cfg_we(cfg_we2),
        .cfg_pol(cfg_pol2), .pol(pol2), .y(y2), .chg(chg2)
    );

    // Reference: each channel sees its input delayed by the synchroniser depth,
    // and accepts a new level once it has differed for a run of F edges.
    int            m1_hist [C1];
    int            m1_run  [C1];
    logic [C1-1:0] m1_s, m1_chg, m1_pol;
    int            m2_hist, m2_run;
    logic          m2_s, m2_chg, m2_pol;

    task automatic model_edge(input int stages, input int filt, input bit ain,
                              input bit hld, input int hist_i, input bit s_i,
                              input int run_i, output int hist_o, output bit s_o,
                              output int run_o, output bit chg_o);
        bit synced;
        synced = ((hist_i >> (stages - 1)) & 1) != 0;
        s_o    = s_i;
        run_o  = run_i;
        chg_o  = 1'b0;
        if (!hld) begin
            if (synced != s_i) begin
                run_o = run_i + 1;
                if (run_o == filt) begin
                    s_o   = synced;
                    run_o = 0;
                    chg_o = 1'b1;
                end
            end else begin
                run_o = 0;
            end
        end
        hist_o = (hist_i << 1) | int'(ain);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C1; i++) begin
                m1_hist[i] = 0;
                m1_run[i]  = 0;
            end
            m1_s   = '0;
            m1_chg = '0;
            m1_pol = '1;
            m2_hist = 0;
            m2_run  = 0;
            m2_s    = 1'b0;
            m2_chg  = 1'b0;
            m2_pol  = 1'b1;
        end else begin
            for (int i = 0; i < C1; i++) begin
                int h, r;
                bit so, co;
                model_edge(S1, F1, a1[i], hold1, m1_hist[i], m1_s[i], m1_run[i], h, so, r, co);
                m1_hist[i] = h;
                m1_s[i]    = so;
                m1_run[i]  = r;
                m1_chg[i]  = co;
            end
            if (cfg_we1) m1_pol = cfg_pol1;
            begin
                int h, r;
                bit so, co;
                model_edge(S2, F2, a2[0], hold2, m2_hist, m2_s, m2_run, h, so, r, co);
                m2_hist = h;
                m2_s    = so;
                m2_run  = r;
                m2_chg  = co;
            end
            if (cfg_we2) m2_pol = cfg_pol2[0];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [C1-1:0] a;
        logic [C1-1:0] exp_y;
        logic [C1-1:0] exp_chg;
    } vec_t;

    function automatic vec_t mk(input logic [C1-1:0] av, input logic [C1-1:0] ey,
                                input logic [C1-1:0] ec);
        vec_t v;
        v.a       = av;
        v.exp_y   = ey;
        v.exp_chg = ec;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        logic exp_y2_seq   [6];
        logic exp_chg2_seq [6];

        // Steady a[0], a 3-cycle glitch on a[2], then a 4-cycle pulse on a[2].
        for (int i = 0; i < 5; i++) tbl.push_back(mk(6'h01, 6'h3F, 6'h00));
        tbl.push_back(mk(6'h01, 6'h3E, 6'h01));
        tbl.push_back(mk(6'h01, 6'h3E, 6'h00));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(6'h05, 6'h3E, 6'h00));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(6'h01, 6'h3E, 6'h00));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(6'h05, 6'h3E, 6'h00));
        tbl.push_back(mk(6'h01, 6'h3E, 6'h00));
        tbl.push_back(mk(6'h01, 6'h3A, 6'h04));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(6'h01, 6'h3A, 6'h00));
        tbl.push_back(mk(6'h01, 6'h3E, 6'h04));
        tbl.push_back(mk(6'h01, 6'h3E, 6'h00));

        exp_y2_seq   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_chg2_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        rst_n    = 1'b0;
        a1       = '0;
        hold1    = 1'b0;
        cfg_we1  = 1'b0;
        cfg_pol1 = '0;
        a2       = '0;
        hold2    = 1'b0;
        cfg_we2  = 1'b0;
        cfg_pol2 = '0;

        repeat (2) @(negedge clk);
        check("reset_y",    32'(y1),   32'h3F);
        check("reset_pol",  32'(pol1), 32'h3F);
        check("reset_chg",  32'(chg1), 32'h00);
        check("reset_y2",   32'(y2),   32'h1);
        check("reset_chg2", 32'(chg2), 32'h0);

        rst_n = 1'b1;
        foreach (tbl[i]) begin
            a1 = tbl[i].a;
            @(negedge clk);
            check($sformatf("tbl%0d_y", i),   32'(y1),   32'(tbl[i].exp_y));
            check($sformatf("tbl%0d_chg", i), 32'(chg1), 32'(tbl[i].exp_chg));
        end

        // Polarity write on a settled bus.
        a1 = 6'h2A;
        repeat (10) @(negedge clk);
        check("settled_y", 32'(y1), 32'h15);
        cfg_we1  = 1'b1;
        cfg_pol1 = 6'h00;
        @(negedge clk);
        cfg_we1 = 1'b0;
        check("polwr_y",   32'(y1),   32'h2A);
        check("polwr_pol", 32'(pol1), 32'h00);
        check("polwr_chg", 32'(chg1), 32'h00);

        // Hold freezes acceptance while a[5] changes.
        hold1 = 1'b1;
        a1    = 6'h0A;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d_y", k), 32'(y1), 32'h2A);
        end
        hold1 = 1'b0;
        for (int k = 1; k <= F1; k++) begin
            @(negedge clk);
            check($sformatf("unhold%0d_y", k),   32'(y1),   (k < F1) ? 32'h2A : 32'h0A);
            check($sformatf("unhold%0d_chg", k), 32'(chg1), (k < F1) ? 32'h00 : 32'h20);
        end

        // Asynchronous reset mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        check("areset_y",   32'(y1),   32'h3F);
        check("areset_pol", 32'(pol1), 32'h3F);
        check("areset_chg", 32'(chg1), 32'h00);
        check("areset_y2",  32'(y2),   32'h1);

        // After release: full latency on the held level, and a 1-cycle pulse
        // through the unfiltered instance.
        @(negedge clk);
        rst_n = 1'b1;
        a2    = 1'b1;
        for (int k = 1; k <= S1 + F1; k++) begin
            @(negedge clk);
            a2 = 1'b0;
            check($sformatf("relat%0d_y", k),   32'(y1),   (k < S1 + F1) ? 32'h3F : 32'h35);
            check($sformatf("relat%0d_chg", k), 32'(chg1), (k < S1 + F1) ? 32'h00 : 32'h0A);
            check($sformatf("pulse%0d_y2", k),   32'(y2),   32'(exp_y2_seq[k-1]));
            check($sformatf("pulse%0d_chg2", k), 32'(chg2), 32'(exp_chg2_seq[k-1]));
        end

        // Random traffic against the reference.
        for (int n = 0; n < 2000; n++) begin
            a1       = a1 ^ (6'($urandom) & 6'($urandom) & 6'($urandom));
            hold1    = ($urandom_range(0, 7) == 0);
            cfg_we1  = ($urandom_range(0, 9) == 0);
            cfg_pol1 = 6'($urandom);
            a2       = a2 ^ 1'($urandom_range(0, 2) == 0);
            hold2    = ($urandom_range(0, 7) == 0);
            cfg_we2  = ($urandom_range(0, 9) == 0);
            cfg_pol2 = 1'($urandom);
            @(negedge clk);
            check("rnd_y",    32'(y1),   32'(m1_s ^ m1_pol));
            check("rnd_pol",  32'(pol1), 32'(m1_pol));
            check("rnd_chg",  32'(chg1), 32'(m1_chg));
            check("rnd_y2",   32'(y2),   32'(m2_s ^ m2_pol));
            check("rnd_pol2", 32'(pol2), 32'(m2_pol));
            check("rnd_chg2", 32'(chg2), 32'(m2_chg));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
